goertzel_frame_sched: RTL and testbench
=======================================

// Module: goertzel_frame_sched
// PURPOSE
//  Frame scheduler in front of the goertzel_sdf_ff Goertzel core. Buffers an input sample
//  stream, paces one sample per core slot (i_wr strobe), clears the core between frames,
//  captures the BIN_NUM complex results after o_done and re-emits them as a valid/ready stream.
// PARAMETERS
//  WIDTH       12    sample / result width (signed), equals the core's WIDTH
//  N_MAX       512   samples per frame, equals the core's N_MAX
//  BIN_NUM     4     bins per frame, equals the core's BIN_NUM
//  FIFO_DEPTH  16    input sample FIFO depth, power of two, >=2
//  SAMPLE_GAP  14    min cycles between core writes (>= 3*BIN_NUM+2)
//  TIMEOUT_CYC 64    done-watchdog limit (only with GOERTZEL_SCHED_TIMEOUT_EN)
// PORTS
//  i_sys_clk    in   1                      clock, all logic on posedge
//  i_sys_rst_n  in   1                      asynchronous active-low reset
//  i_enable     in   1                      1 = schedule frames; 0 = finish current frame, then idle
//  s_x          in   WIDTH                  input sample
//  s_valid      in   1                      sample valid
//  s_ready      out  1                      FIFO not full
//  o_core_x     out  WIDTH                  sample to core i_x, held stable until next write
//  o_core_wr    out  1                      one-cycle write strobe to core i_wr
//  o_core_clr   out  1                      one-cycle active-high clear to core i_sys_rst
//  i_core_done  in   1                      core o_done
//  i_core_y     in   2 x WIDTH              core o_y {[1]=im,[0]=re}
//  m_re, m_im   out  WIDTH                  result bin, real / imaginary
//  m_bin        out  $clog2(BIN_NUM)        bin index
//  m_last       out  1                      high on bin BIN_NUM-1
//  m_valid      out  1                      result valid
//  m_ready      in   1                      downstream accept
//  o_frame_cnt  out  16                     completed frames, wraps at 2^16
//  o_busy       out  1                      state != IDLE
//  o_timeout    out  1                      sticky watchdog flag
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state IDLE; s_ready is 1 on the first cycle after reset release.
//  - s_ready = !full. Push on s_valid & s_ready, independent of state; no samples are dropped.
//  - FSM:
//    - IDLE: if i_enable -> CLEAR.
//    - CLEAR: o_core_clr=1 for one cycle; sample_cnt=0; gap_cnt=0 -> FEED.
//    - FEED: if FIFO non-empty and gap_cnt==0: pop, drive o_core_x, pulse o_core_wr,
//      gap_cnt=SAMPLE_GAP-1, sample_cnt++. After write N_MAX -> WAIT_DONE. An empty FIFO only stalls.
//    - WAIT_DONE: on the first cycle with i_core_done=1 -> CAPTURE.
//    - CAPTURE: latch i_core_y into result buffer entry k on BIN_NUM consecutive cycles
//      (k=0..BIN_NUM-1); entry 0 is taken the cycle after done is seen -> DRAIN.
//    - DRAIN: m_valid=1 with entry k; advance on m_valid&m_ready; after the beat with m_last:
//      o_frame_cnt++, then -> CLEAR if i_enable, else -> IDLE.
//  - Latency: first o_core_wr 2 cycles after enable when the FIFO is non-empty. Writes are
//    never closer than SAMPLE_GAP cycles.
//  - m_* outputs are held stable while m_valid & !m_ready.
//  - gap_cnt decrements every cycle to 0 in every state.
//  - Dropping i_enable mid-frame does not abort: the frame completes and drains.
//  - Reset mid-frame: the FSM returns to IDLE. The next frame always starts via CLEAR, so the
//    core is cleared before reuse. FIFO contents are lost.
//  - Results pass through unmodified; no arithmetic on sample or result widths.
// CONFIGURATION
//  - GOERTZEL_SCHED_TIMEOUT_EN defined:
//    - A counter runs in WAIT_DONE and CAPTURE.
//    - If done is not seen within TIMEOUT_CYC cycles of entering WAIT_DONE: set o_timeout
//      (cleared only by reset), discard the frame (no DRAIN, o_frame_cnt unchanged), -> CLEAR.
//  - Not defined: WAIT_DONE waits indefinitely; o_timeout is tied to 0.
// STRUCTURE
//  - goertzel_pkg:
//    - sched_state_e {IDLE, CLEAR, FEED, WAIT_DONE, CAPTURE, DRAIN}
//    - typedef cplx_t {re, im} of WIDTH
//    - function for minimum SAMPLE_GAP
//  - Sub-module goertzel_sample_fifo: synchronous FIFO (WIDTH, FIFO_DEPTH) with push/pop,
//    full/empty; pop data valid in the same cycle as pop.
//  - Result buffer: BIN_NUM x cplx_t register array, inline.
// TESTING
//  1. Reset: hold i_sys_rst_n=0 with s_valid=1 -> all outputs 0; s_ready=1 the cycle after release.
//  2. N_MAX=8, BIN_NUM=4: 8 samples back-to-back, i_enable=1 -> one clr pulse; 8 wr pulses
//     exactly 14 cycles apart; o_core_x = input order.
//  3. Core model asserts done with y={k,-k} for k=0..3 -> 4 beats m_re=0,1,2,3, m_im=0,-1,-2,-3;
//     m_last on bin 3; o_frame_cnt=1.
//  4. Hold m_ready=0 for 10 cycles in DRAIN -> m_* stable. FIFO fills: s_ready=0 after
//     16 unpopped samples and no sample is lost.
//  5. Drop i_enable after write 3 -> frame completes and drains, then IDLE, o_busy=0;
//     no further clr pulse.
//  6. (TIMEOUT_EN) done never asserted -> o_timeout=1 at 64 cycles, clr pulse, no m_valid,
//     o_frame_cnt unchanged.

Source files
------------

// File: rtl/goertzel_pkg.sv
// Shared types and helpers for the Goertzel frame scheduler.
package goertzel_pkg;

    localparam int unsigned GZ_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        WAIT_DONE,
        CAPTURE,
        DRAIN
    } sched_state_e;

    typedef struct packed {
        logic signed [GZ_WIDTH-1:0] im;
        logic signed [GZ_WIDTH-1:0] re;
    } cplx_t;

    // The core needs 3 cycles per bin plus 2 between writes to finish its update.
    function automatic int unsigned min_sample_gap(input int unsigned bin_num);
        return 3 * bin_num + 2;
    endfunction

endpackage

// File: rtl/goertzel_frame_sched_if.sv
// Sample input stream and result output stream used by goertzel_frame_sched.
interface goertzel_sample_if #(
    parameter int unsigned WIDTH = 12
);
    logic signed [WIDTH-1:0] x;
    logic                    valid;
    logic                    ready;

    modport master (output x, output valid, input ready);
    modport slave  (input x, input valid, output ready);
endinterface

interface goertzel_result_if #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned BIN_NUM = 4
);
    localparam int unsigned BIN_W = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;

    logic signed [WIDTH-1:0] re;
    logic signed [WIDTH-1:0] im;
    logic [BIN_W-1:0]        bin;
    logic                    last;
    logic                    valid;
    logic                    ready;

    modport master (output re, output im, output bin, output last, output valid, input ready);
    modport slave  (input re, input im, input bin, input last, input valid, output ready);
endinterface

// File: rtl/goertzel_sample_fifo.sv
// Synchronous show-ahead FIFO: pop_data presents the head entry in the cycle it is popped.
module goertzel_sample_fifo #(
    parameter int unsigned WIDTH      = 12,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/goertzel_frame_sched.sv
// Frame scheduler for the goertzel_sdf_ff core: buffers samples, paces core writes, clears
// the core per frame and re-streams captured bins. Done watchdog: GOERTZEL_SCHED_TIMEOUT_EN.
module goertzel_frame_sched
    import goertzel_pkg::*;
#(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned N_MAX       = 512,
    parameter int unsigned BIN_NUM     = 4,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned SAMPLE_GAP  = 14,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                     i_sys_clk,
    input  logic                     i_sys_rst_n,
    input  logic                     i_enable,
    goertzel_sample_if.slave         s,
    output logic signed [WIDTH-1:0]  o_core_x,
    output logic                     o_core_wr,
    output logic                     o_core_clr,
    input  logic                     i_core_done,
    input  logic [1:0][WIDTH-1:0]    i_core_y,
    goertzel_result_if.master        m,
    output logic [15:0]              o_frame_cnt,
    output logic                     o_busy,
    output logic                     o_timeout
);

    // A gap below the core's minimum would corrupt its state, so it is clamped up.
    localparam int unsigned GAP_EFF = (SAMPLE_GAP > min_sample_gap(BIN_NUM)) ?
                                      SAMPLE_GAP : min_sample_gap(BIN_NUM);
    localparam int unsigned GAP_W   = $clog2(GAP_EFF + 1);
    localparam int unsigned CNT_W   = $clog2(N_MAX + 1);
    localparam int unsigned BIN_W   = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;

    typedef struct packed {
        logic signed [WIDTH-1:0] im;
        logic signed [WIDTH-1:0] re;
    } res_t;

    sched_state_e            state_q, state_d;
    logic [CNT_W-1:0]        sample_cnt_q;
    logic [GAP_W-1:0]        gap_cnt_q;
    logic [BIN_W-1:0]        bin_idx_q;
    logic signed [WIDTH-1:0] x_hold_q;
    logic                    rdy_en_q;
    res_t                    res_buf_q [BIN_NUM];

    logic             fifo_full, fifo_empty, push;
    logic [WIDTH-1:0] fifo_head;
    logic             wr_fire, bin_last, to_expire;

    assign push     = s.valid && s.ready;
    assign s.ready  = rdy_en_q && !fifo_full;
    assign bin_last = (bin_idx_q == BIN_W'(BIN_NUM - 1));

    goertzel_sample_fifo #(
        .WIDTH      (WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_sys_clk),
        .rst_n     (i_sys_rst_n),
        .push      (push),
        .push_data (s.x),
        .pop       (wr_fire),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        o_core_clr = 1'b0;
        wr_fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_enable) state_d = CLEAR;
            end
            CLEAR: begin
                o_core_clr = 1'b1;
                state_d    = FEED;
            end
            FEED: begin
                if (!fifo_empty && gap_cnt_q == '0) begin
                    wr_fire = 1'b1;
                    if (sample_cnt_q == CNT_W'(N_MAX - 1)) state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (i_core_done)    state_d = CAPTURE;
                else if (to_expire) state_d = CLEAR;
            end
            CAPTURE: begin
                if (bin_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (m.ready && bin_last) state_d = i_enable ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The write cycle shows the popped sample directly; the register holds it afterwards.
    assign o_core_wr = wr_fire;
    assign o_core_x  = wr_fire ? $signed(fifo_head) : x_hold_q;
    assign o_busy    = (state_q != IDLE);
    assign m.valid   = (state_q == DRAIN);
    assign m.last    = (state_q == DRAIN) && bin_last;
    assign m.bin     = bin_idx_q;
    assign m.re      = res_buf_q[bin_idx_q].re;
    assign m.im      = res_buf_q[bin_idx_q].im;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            gap_cnt_q    <= '0;
            bin_idx_q    <= '0;
            x_hold_q     <= '0;
            rdy_en_q     <= 1'b0;
            o_frame_cnt  <= '0;
            for (int unsigned i = 0; i < BIN_NUM; i++) begin
                res_buf_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;

            if (wr_fire)             gap_cnt_q <= GAP_W'(GAP_EFF - 1);
            else if (o_core_clr)     gap_cnt_q <= '0;
            else if (gap_cnt_q != '0) gap_cnt_q <= gap_cnt_q - 1'b1;

            if (o_core_clr)   sample_cnt_q <= '0;
            else if (wr_fire) sample_cnt_q <= sample_cnt_q + 1'b1;

            if (wr_fire) x_hold_q <= $signed(fifo_head);

            case (state_q)
                CLEAR: bin_idx_q <= '0;
                CAPTURE: begin
                    res_buf_q[bin_idx_q] <= res_t'(i_core_y);
                    bin_idx_q            <= bin_last ? '0 : bin_idx_q + 1'b1;
                end
                DRAIN: begin
                    if (m.ready) begin
                        bin_idx_q <= bin_last ? '0 : bin_idx_q + 1'b1;
                        if (bin_last) o_frame_cnt <= o_frame_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GOERTZEL_SCHED_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            to_flag_q;

    assign to_expire = (state_q == WAIT_DONE) && !i_core_done &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
    assign o_timeout = to_flag_q;

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            if (state_q == WAIT_DONE || state_q == CAPTURE) to_cnt_q <= to_cnt_q + 1'b1;
            else                                           to_cnt_q <= '0;
            if (to_expire) to_flag_q <= 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout_cyc;

    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign to_expire          = 1'b0;
    assign o_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_goertzel_frame_sched.sv
// Self-checking bench for goertzel_frame_sched with a behavioural core model and sample/result queues.
module tb_goertzel_frame_sched;
    import goertzel_pkg::*;

    localparam int unsigned WIDTH       = 12;
    localparam int unsigned N_MAX       = 8;
    localparam int unsigned BIN_NUM     = 4;
    localparam int unsigned FIFO_DEPTH  = 16;
    localparam int unsigned SAMPLE_GAP  = 14;
    localparam int unsigned TIMEOUT_CYC = 64;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    enable = 1'b0;
    logic signed [WIDTH-1:0] core_x;
    logic                    core_wr, core_clr;
    logic                    core_done;
    logic [1:0][WIDTH-1:0]   core_y;
    logic [15:0]             frame_cnt;
    logic                    busy, timeout;

    goertzel_sample_if #(.WIDTH(WIDTH)) s_if ();
    goertzel_result_if #(.WIDTH(WIDTH), .BIN_NUM(BIN_NUM)) m_if ();

    goertzel_frame_sched #(
        .WIDTH       (WIDTH),
        .N_MAX       (N_MAX),
        .BIN_NUM     (BIN_NUM),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .SAMPLE_GAP  (SAMPLE_GAP),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .i_sys_clk   (clk),
        .i_sys_rst_n (rst_n),
        .i_enable    (enable),
        .s           (s_if),
        .o_core_x    (core_x),
        .o_core_wr   (core_wr),
        .o_core_clr  (core_clr),
        .i_core_done (core_done),
        .i_core_y    (core_y),
        .m           (m_if),
        .o_frame_cnt (frame_cnt),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic signed [WIDTH-1:0] sample_q [$];
    logic signed [WIDTH-1:0] wr_log [$];
    int unsigned             wr_cyc [$];
    int unsigned             clr_log [$];
    int unsigned             mvalid_cnt = 0;
    cplx_t                   exp_q [$];

    always @(negedge clk) begin
        if (core_wr) begin
            wr_log.push_back(core_x);
            wr_cyc.push_back(cyc);
        end
        if (core_clr) clr_log.push_back(cyc);
        if (m_if.valid) mvalid_cnt <= mvalid_cnt + 1;
    end

    // Core model: counts writes since clear, answers N_MAX writes with done then one bin per cycle.
    bit          core_respond = 1'b1;
    int unsigned core_wr_cnt = 0;
    int unsigned frame_no = 0;
    initial begin
        cplx_t r;
        core_done = 1'b0;
        core_y    = '0;
        forever begin
            @(negedge clk);
            if (core_clr) core_wr_cnt = 0;
            if (core_wr) core_wr_cnt++;
            if (core_wr_cnt == N_MAX) begin
                core_wr_cnt = 0;
                if (core_respond) begin
                    repeat (3) @(negedge clk);
                    core_done = 1'b1;
                    @(negedge clk);
                    core_done = 1'b0;
                    for (int k = 0; k < int'(BIN_NUM); k++) begin
                        if (frame_no == 0) begin
                            r.re = WIDTH'(k);
                            r.im = -WIDTH'(k);
                        end else begin
                            r.re = WIDTH'($urandom);
                            r.im = WIDTH'($urandom);
                        end
                        core_y = r;
                        exp_q.push_back(r);
                        @(negedge clk);
                    end
                    core_y = '0;
                    frame_no++;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic signed [WIDTH-1:0] v);
        int unsigned waited = 0;
        s_if.x     = v;
        s_if.valid = 1'b1;
        while (!s_if.ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!s_if.ready) check("send_ready", s_if.ready, 1);
        @(negedge clk);
        sample_q.push_back(v);
        s_if.valid = 1'b0;
    endtask

    task automatic wait_writes(input int unsigned n, input int unsigned budget);
        int unsigned t = 0;
        while (wr_log.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("write_count", wr_log.size(), n);
    endtask

    task automatic check_writes(input int unsigned lo, input int unsigned hi);
        for (int unsigned i = lo; i < hi && i < wr_log.size(); i++) begin
            check("core_x", wr_log[i], sample_q[i]);
            if (i > lo) check("wr_gap", wr_cyc[i] - wr_cyc[i-1], SAMPLE_GAP);
        end
    endtask

    task automatic drain_frame(input int unsigned budget);
        int unsigned beats = 0;
        int unsigned t = 0;
        cplx_t e;
        while (beats < BIN_NUM && t < budget) begin
            m_if.ready = ($urandom_range(0, 3) != 0);
            if (m_if.valid && m_if.ready) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else                   e = '0;
                check("m_re", m_if.re, e.re);
                check("m_im", m_if.im, e.im);
                check("m_bin", m_if.bin, beats);
                check("m_last", m_if.last, beats == BIN_NUM - 1);
                beats++;
            end
            @(negedge clk);
            t++;
        end
        m_if.ready = 1'b0;
        check("drain_beats", beats, BIN_NUM);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned en_cyc, t, clr_before, mv_base, last_wr;
        logic [63:0] held;

        s_if.x      = WIDTH'($urandom);
        s_if.valid  = 1'b1;
        m_if.ready  = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outs", {s_if.ready, core_x, core_wr, core_clr, m_if.re, m_if.im, m_if.bin,
                             m_if.last, m_if.valid, frame_cnt, busy, timeout}, '0);
        s_if.valid = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        check("ready_after_reset", s_if.ready, 1);
        check("idle_after_reset", busy, 0);

        // Frame 1: prefilled FIFO, fixed-pattern results, long downstream stall.
        for (int i = 0; i < int'(N_MAX); i++) send(WIDTH'($urandom));
        enable = 1'b1;
        en_cyc = cyc;
        wait_writes(N_MAX, N_MAX * SAMPLE_GAP + 20);
        check("clr_count_f1", clr_log.size(), 1);
        if (clr_log.size() > 0) check("clr_latency", clr_log[0], en_cyc + 1);
        if (wr_cyc.size() > 0) check("first_wr_latency", wr_cyc[0], en_cyc + 2);
        check_writes(0, N_MAX);

        t = 0;
        while (!m_if.valid && t < 60) begin
            @(negedge clk);
            t++;
        end
        check("drain_valid", m_if.valid, 1);
        held = {m_if.valid, m_if.re, m_if.im, m_if.bin, m_if.last};
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            send(WIDTH'($urandom));
            check("hold_stable", {m_if.valid, m_if.re, m_if.im, m_if.bin, m_if.last}, held);
        end
        s_if.x     = WIDTH'($urandom);
        s_if.valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("fifo_full_ready", s_if.ready, 0);
            @(negedge clk);
        end
        s_if.valid = 1'b0;
        check("hold_stable_end", {m_if.valid, m_if.re, m_if.im, m_if.bin, m_if.last}, held);
        drain_frame(200);
        check("frame_cnt_1", frame_cnt, 1);

        // Frame 2 starts from the still-high enable; enable drops after its third write.
        wait_writes(N_MAX + 3, 200);
        enable = 1'b0;
        wait_writes(2 * N_MAX, 200);
        check("clr_count_f2", clr_log.size(), 2);
        check_writes(N_MAX, 2 * N_MAX);
        drain_frame(200);
        check("frame_cnt_2", frame_cnt, 2);
        repeat (3) @(negedge clk);
        check("idle_after_disable", busy, 0);
        clr_before = clr_log.size();
        repeat (20) @(negedge clk);
        check("no_extra_clr", clr_log.size(), clr_before);
        check("still_idle", busy, 0);

        // Frame 3 consumes the samples left over from the full-FIFO phase.
        enable = 1'b1;
        en_cyc = cyc;
        wait_writes(2 * N_MAX + 1, 40);
        enable = 1'b0;
        if (wr_cyc.size() > 2 * N_MAX) check("f3_wr_latency", wr_cyc[2*N_MAX], en_cyc + 2);
        wait_writes(3 * N_MAX, 200);
        check_writes(2 * N_MAX, 3 * N_MAX);
        drain_frame(200);
        check("frame_cnt_3", frame_cnt, 3);
        check("no_sample_lost", wr_log.size(), sample_q.size());
        check("fifo_empty_ready", s_if.ready, 1);

`ifdef GOERTZEL_SCHED_TIMEOUT_EN
        core_respond = 1'b0;
        mv_base      = mvalid_cnt;
        for (int i = 0; i < int'(N_MAX); i++) send(WIDTH'($urandom));
        enable = 1'b1;
        wait_writes(4 * N_MAX, N_MAX * SAMPLE_GAP + 40);
        check_writes(3 * N_MAX, 4 * N_MAX);
        last_wr = (wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : 0;
        t = 0;
        while (!timeout && t < 150) begin
            @(negedge clk);
            t++;
        end
        check("timeout_cycle", cyc, last_wr + TIMEOUT_CYC + 1);
        check("timeout_clr", core_clr, 1);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        check("timeout_sticky", timeout, 1);
        check("timeout_no_valid", mvalid_cnt - mv_base, 0);
        check("timeout_frame_cnt", frame_cnt, 3);
`else
        t = 0; mv_base = 0; last_wr = 0;
        check("timeout_tied_low", timeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
